// File: rtl/mdc_twiddle_ctrl_if.sv
//------------------------------------------------------------------------------
// Module      : mdc_twiddle_ctrl_if
// Description : Signal bundle between the MDC FFT datapath (master) and the
//               twiddle/stage-sequencing controller (slave). The tw_trivial
//               bus exists only when MDC_TWCTRL_TRIVIAL_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mdc_twiddle_ctrl_if;
    logic       clr;
    logic       in_valid;
    logic [3:0] rom_32_counter;
    logic [2:0] rom_16_counter;
    logic [2:0] rom_8_counter;
    logic [1:0] rom_4_counter;
    logic [3:0] stage_en;
    logic       out_valid;
    logic       frame_done;
`ifdef MDC_TWCTRL_TRIVIAL_EN
    logic [3:0] tw_trivial;

    modport master (
        output clr, in_valid,
        input  rom_32_counter, rom_16_counter, rom_8_counter, rom_4_counter,
        input  stage_en, out_valid, frame_done, tw_trivial
    );
    modport slave (
        input  clr, in_valid,
        output rom_32_counter, rom_16_counter, rom_8_counter, rom_4_counter,
        output stage_en, out_valid, frame_done, tw_trivial
    );
`else
    modport master (
        output clr, in_valid,
        input  rom_32_counter, rom_16_counter, rom_8_counter, rom_4_counter,
        input  stage_en, out_valid, frame_done
    );
    modport slave (
        input  clr, in_valid,
        output rom_32_counter, rom_16_counter, rom_8_counter, rom_4_counter,
        output stage_en, out_valid, frame_done
    );
`endif
endinterface

`default_nettype wire

// File: rtl/mdc_twiddle_ctrl.sv
//------------------------------------------------------------------------------
// Module      : mdc_twiddle_ctrl
// Description : Twiddle-index and stage-enable sequencer for a 32-point
//               radix-2 MDC FFT. A valid shift register taps the per-stage
//               latencies; per-stage mod-16 counters feed the ROM indices and
//               the output counter flags the 16th output pair of a frame.
//               Optional feature macro: MDC_TWCTRL_TRIVIAL_EN (adds tw_trivial).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mdc_twiddle_ctrl #(
    parameter int D1   = 9,
    parameter int D2   = 14,
    parameter int D3   = 17,
    parameter int D4   = 19,
    parameter int DOUT = 21
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mdc_twiddle_ctrl_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } stage_state_t;

    // Stage latencies in strobe order: stages 1..4 then the FFT output.
    localparam int c_tap [5] = '{D1, D2, D3, D4, DOUT};

    if (!(1 <= D1 && D1 < D2 && D2 < D3 && D3 < D4 && D4 < DOUT && DOUT <= 32))
    begin : g_param_check
        $error("mdc_twiddle_ctrl: latencies must satisfy 1 <= D1 < D2 < D3 < D4 < DOUT <= 32");
    end

    // Taps beyond DOUT are never observed, so the line stops at the output tap.
    logic [DOUT-1:0] r_vld_sr;

    // Valid delay line; a flush discards every in-flight pair, including one
    // offered on the flush cycle itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_sr <= '0;
        end else if (bus.clr) begin
            r_vld_sr <= '0;
        end else begin
            r_vld_sr <= {r_vld_sr[DOUT-2:0], bus.in_valid};
        end
    end

    // Per-strobe sequencer: state is RUN exactly in the cycles the tap is high.
    // r_idx is loaded one cycle ahead of the strobe so the ROM index is a
    // register that already shows the index of the pair being strobed, and
    // holds that index through gaps.
    for (genvar gi = 0; gi < 5; gi++) begin : g_stage
        localparam int c_t = c_tap[gi];

        logic         w_pre;
        stage_state_t r_state;
        stage_state_t w_state_nxt;
        logic [3:0]   r_cnt;
        logic [3:0]   w_cnt_nxt;
        logic [3:0]   r_idx;
        logic [3:0]   w_idx_nxt;

        if (c_t == 1) begin : g_pre_in
            assign w_pre = bus.in_valid;
        end else begin : g_pre_sr
            assign w_pre = r_vld_sr[c_t-2];
        end

        // Next-state, counter advance and index preload.
        always_comb begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = r_cnt;
            w_idx_nxt   = r_idx;
            if (w_pre) begin
                w_state_nxt = ST_RUN;
            end
            case (r_state)
                ST_RUN:  w_cnt_nxt = r_cnt + 4'd1;
                default: w_cnt_nxt = r_cnt;
            endcase
            if (w_pre) begin
                w_idx_nxt = w_cnt_nxt;
            end
        end

        // State, counter and index registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_idx   <= '0;
            end else if (bus.clr) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_idx   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_idx   <= w_idx_nxt;
            end
        end
    end

    logic [3:0] w_stage_en;
    logic       w_out_valid;

    assign w_stage_en  = {r_vld_sr[D4-1], r_vld_sr[D3-1], r_vld_sr[D2-1], r_vld_sr[D1-1]};
    assign w_out_valid = r_vld_sr[DOUT-1];

    assign bus.stage_en       = w_stage_en;
    assign bus.out_valid      = w_out_valid;
    assign bus.rom_32_counter = g_stage[0].r_idx;
    assign bus.rom_16_counter = g_stage[1].r_idx[2:0];
    assign bus.rom_8_counter  = {1'b0, g_stage[2].r_idx[1:0]};
    assign bus.rom_4_counter  = g_stage[3].r_idx[1:0];
    assign bus.frame_done     = w_out_valid && (g_stage[4].r_cnt == 4'd15);

`ifdef MDC_TWCTRL_TRIVIAL_EN
    // Index 0 means twiddle = 1, so the datapath may bypass its multiplier.
    assign bus.tw_trivial = {
        w_stage_en[3] && (g_stage[3].r_idx[1:0] == 2'd0),
        w_stage_en[2] && (g_stage[2].r_idx[1:0] == 2'd0),
        w_stage_en[1] && (g_stage[1].r_idx[2:0] == 3'd0),
        w_stage_en[0] && (g_stage[0].r_idx     == 4'd0)
    };
`endif

    // Upper index bits of the smaller ROMs and the output-stage index are
    // carried by the shared sequencer but never needed.
    logic w_unused_idx;
    assign w_unused_idx = &{1'b0, g_stage[1].r_idx[3], g_stage[2].r_idx[3:2],
                            g_stage[3].r_idx[3:2], g_stage[4].r_idx};

endmodule

`default_nettype wire

// File: tb/tb_mdc_twiddle_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_mdc_twiddle_ctrl
// Description : Directed self-checking bench for mdc_twiddle_ctrl with the
//               default latencies (9/14/17/19/21). Inputs change on the falling
//               edge; outputs are sampled on the falling edge before driving.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mdc_twiddle_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mdc_twiddle_ctrl_if bus ();

    mdc_twiddle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flush via clr, leaving one idle cycle before cycle 0 of the next test.
    task automatic do_clear();
        @(negedge clk);
        bus.clr      = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.clr      = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.clr      = 1'b0;
        bus.in_valid = 1'b0;
        #3;
        n_checks++;
        if ({bus.stage_en, bus.out_valid, bus.frame_done} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_strobes got=%b want=000000", {bus.stage_en, bus.out_valid, bus.frame_done});
        end
        n_checks++;
        if ({bus.rom_32_counter, bus.rom_16_counter, bus.rom_8_counter, bus.rom_4_counter} !== 12'h0) begin
            n_errors++;
            $display("FAIL reset_roms got=%h want=000",
                     {bus.rom_32_counter, bus.rom_16_counter, bus.rom_8_counter, bus.rom_4_counter});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_frame();
        logic [3:0] e_en;
        do_clear();
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            e_en = {(c >= 19 && c <= 34), (c >= 17 && c <= 32), (c >= 14 && c <= 29), (c >= 9 && c <= 24)};
            n_checks++;
            if (bus.stage_en !== e_en) begin
                n_errors++;
                $display("FAIL single_stage_en c=%0d got=%b want=%b", c, bus.stage_en, e_en);
            end
            n_checks++;
            if (bus.out_valid !== (c >= 21 && c <= 36)) begin
                n_errors++;
                $display("FAIL single_out_valid c=%0d got=%b", c, bus.out_valid);
            end
            n_checks++;
            if (bus.frame_done !== (c == 36)) begin
                n_errors++;
                $display("FAIL single_frame_done c=%0d got=%b", c, bus.frame_done);
            end
            n_checks++;
            if (bus.rom_32_counter !== ((c < 9) ? 4'd0 : (c > 24) ? 4'd15 : 4'(c - 9))) begin
                n_errors++;
                $display("FAIL single_rom32 c=%0d got=%0d", c, bus.rom_32_counter);
            end
            if (c >= 14 && c <= 29) begin
                n_checks++;
                if (bus.rom_16_counter !== 3'((c - 14) % 8)) begin
                    n_errors++;
                    $display("FAIL single_rom16 c=%0d got=%0d want=%0d", c, bus.rom_16_counter, (c - 14) % 8);
                end
            end
            if (c >= 17 && c <= 32) begin
                n_checks++;
                if (bus.rom_8_counter !== 3'((c - 17) % 4)) begin
                    n_errors++;
                    $display("FAIL single_rom8 c=%0d got=%0d want=%0d", c, bus.rom_8_counter, (c - 17) % 4);
                end
            end
            if (c >= 19 && c <= 34) begin
                n_checks++;
                if (bus.rom_4_counter !== 2'((c - 19) % 4)) begin
                    n_errors++;
                    $display("FAIL single_rom4 c=%0d got=%0d want=%0d", c, bus.rom_4_counter, (c - 19) % 4);
                end
            end
            bus.in_valid = (c < 16);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_gaps();
        logic [4:0] pat;
        logic [3:0] exp_r32 [5];
        logic [1:0] exp_r4 [5];
        pat = 5'b01101; // cycle 0 in bit 0: 1,0,1,1,0
        exp_r32 = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd2};
        exp_r4  = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2};
        do_clear();
        for (int c = 0; c <= 30; c++) begin
            @(negedge clk);
            if (c >= 9 && c <= 13) begin
                n_checks++;
                if (bus.stage_en[0] !== pat[c-9] || bus.rom_32_counter !== exp_r32[c-9]) begin
                    n_errors++;
                    $display("FAIL gap_stage1 c=%0d got en=%b idx=%0d want en=%b idx=%0d",
                             c, bus.stage_en[0], bus.rom_32_counter, pat[c-9], exp_r32[c-9]);
                end
            end
            if (c >= 19 && c <= 23) begin
                n_checks++;
                if (bus.stage_en[3] !== pat[c-19] || bus.rom_4_counter !== exp_r4[c-19]) begin
                    n_errors++;
                    $display("FAIL gap_stage4 c=%0d got en=%b idx=%0d want en=%b idx=%0d",
                             c, bus.stage_en[3], bus.rom_4_counter, pat[c-19], exp_r4[c-19]);
                end
            end
            if (c >= 21 && c <= 25) begin
                n_checks++;
                if (bus.out_valid !== pat[c-21]) begin
                    n_errors++;
                    $display("FAIL gap_out_valid c=%0d got=%b want=%b", c, bus.out_valid, pat[c-21]);
                end
            end
            bus.in_valid = (c <= 4) ? pat[c] : 1'b0;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        do_clear();
        for (int c = 0; c <= 60; c++) begin
            @(negedge clk);
            if (bus.frame_done === 1'b1) pulses++;
            n_checks++;
            if (bus.frame_done !== (c == 36 || c == 52)) begin
                n_errors++;
                $display("FAIL b2b_frame_done c=%0d got=%b", c, bus.frame_done);
            end
            if (c >= 9 && c <= 40) begin
                n_checks++;
                if (bus.rom_32_counter !== 4'((c - 9) % 16) || bus.stage_en[0] !== 1'b1) begin
                    n_errors++;
                    $display("FAIL b2b_rom32 c=%0d got en=%b idx=%0d want idx=%0d",
                             c, bus.stage_en[0], bus.rom_32_counter, (c - 9) % 16);
                end
            end
            bus.in_valid = (c < 32);
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (pulses != 2) begin
            n_errors++;
            $display("FAIL b2b_pulse_count got=%0d want=2", pulses);
        end
    endtask

    task automatic test_async_reset();
        do_clear();
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            bus.in_valid = (c < 8);
        end
        @(negedge clk);
        n_checks++;
        if (bus.stage_en[0] !== 1'b1 || bus.rom_32_counter !== 4'd3) begin
            n_errors++;
            $display("FAIL arst_pre got en=%b idx=%0d want en=1 idx=3", bus.stage_en[0], bus.rom_32_counter);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.stage_en, bus.out_valid, bus.frame_done, bus.rom_32_counter,
             bus.rom_16_counter, bus.rom_8_counter, bus.rom_4_counter} !== 18'h0) begin
            n_errors++;
            $display("FAIL arst_outputs got en=%b ov=%b fd=%b r32=%0d r16=%0d r8=%0d r4=%0d want all 0",
                     bus.stage_en, bus.out_valid, bus.frame_done, bus.rom_32_counter,
                     bus.rom_16_counter, bus.rom_8_counter, bus.rom_4_counter);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.stage_en[0] !== (c >= 9 && c <= 24) || bus.out_valid !== (c >= 21 && c <= 36)) begin
                n_errors++;
                $display("FAIL arst_refill c=%0d got en0=%b ov=%b", c, bus.stage_en[0], bus.out_valid);
            end
            n_checks++;
            if (bus.frame_done !== (c == 36)) begin
                n_errors++;
                $display("FAIL arst_frame_done c=%0d got=%b", c, bus.frame_done);
            end
            if (c >= 9 && c <= 24) begin
                n_checks++;
                if (bus.rom_32_counter !== 4'(c - 9)) begin
                    n_errors++;
                    $display("FAIL arst_rom32 c=%0d got=%0d want=%0d", c, bus.rom_32_counter, c - 9);
                end
            end
            bus.in_valid = (c < 16);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_clr_collision();
        do_clear();
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (c == 12) begin
                n_checks++;
                if (bus.rom_32_counter !== 4'd3) begin
                    n_errors++;
                    $display("FAIL clr_pre_rom32 got=%0d want=3", bus.rom_32_counter);
                end
            end
            if (c == 13) begin
                n_checks++;
                if (bus.rom_32_counter !== 4'd0) begin
                    n_errors++;
                    $display("FAIL clr_rom32_cleared got=%0d want=0", bus.rom_32_counter);
                end
            end
            if (c >= 13) begin
                n_checks++;
                if (bus.stage_en[0] !== (c == 22) || bus.stage_en[3] !== (c == 32) ||
                    bus.out_valid !== (c == 34) || bus.frame_done !== 1'b0) begin
                    n_errors++;
                    $display("FAIL clr_strobes c=%0d got en=%b ov=%b fd=%b", c, bus.stage_en,
                             bus.out_valid, bus.frame_done);
                end
            end
            if (c == 22) begin
                n_checks++;
                if (bus.rom_32_counter !== 4'd0) begin
                    n_errors++;
                    $display("FAIL clr_next_index got=%0d want=0", bus.rom_32_counter);
                end
            end
            bus.in_valid = (c <= 13);
            bus.clr      = (c == 12);
        end
        bus.in_valid = 1'b0;
        bus.clr      = 1'b0;
    endtask

`ifdef MDC_TWCTRL_TRIVIAL_EN
    task automatic test_trivial();
        do_clear();
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.tw_trivial[3] !== (c >= 19 && c <= 34 && ((c - 19) % 4) == 0) ||
                bus.tw_trivial[0] !== (c == 9)) begin
                n_errors++;
                $display("FAIL trivial c=%0d got=%b", c, bus.tw_trivial);
            end
            bus.in_valid = (c < 16);
        end
        bus.in_valid = 1'b0;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_single_frame();
        test_gaps();
        test_back_to_back();
        test_async_reset();
        test_clr_collision();
`ifdef MDC_TWCTRL_TRIVIAL_EN
        test_trivial();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
